zero_count_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the combinational 32-bit zero detector. Per operand it produces an all-zeros / all-ones flag and a leading-zero / leading-one count, in the EX stage of the MIPS pipeline. These results feed branch-compare (BEQ/BNE zero flag) and the CLZ/CLO instructions. It carries a valid bit and a destination tag, and honours pipeline stall and flush.

---
 rtl/zcp_pkg.sv | 17 +
 rtl/zero_count_pipe_chunk_lzc.sv | 25 ++
 rtl/zero_count_pipe.sv | 104 ++++++++++
 tb/tb_zero_count_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zcp_pkg.sv
// Shared constants for the zero/one counting pipeline and its ALU neighbours.
// Optional ZCP_BYPASS_EN build of zero_count_pipe adds hazard_out.
package zcp_pkg;

    localparam logic MODE_ZEROS = 1'b0;
    localparam logic MODE_ONES  = 1'b1;

    localparam int ZCP_WIDTH = 32;
    localparam int ZCP_CHUNK = 8;
    localparam int ZCP_TAG_W = 5;

    // A count over w bits needs to hold the value w itself.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/zero_count_pipe_chunk_lzc.sv
// chunk_lzc: combinational all-zero flag and leading-zero count for one slice.
module chunk_lzc
    import zcp_pkg::*;
#(
    parameter int CHUNK = ZCP_CHUNK
) (
    input  logic [CHUNK-1:0]        data,
    output logic                    zero,
    output logic [cnt_w(CHUNK)-1:0] cnt
);

    localparam int CW = cnt_w(CHUNK);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        zero = ~|data;
        cnt  = CW'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (data[i]) begin
                cnt = CW'(CHUNK - 1 - i);
            end
        end
    end

endmodule

// File: rtl/zero_count_pipe.sv
// Two-stage all-zeros/all-ones detector with leading-zero/one count, valid and tag.
// Define ZCP_BYPASS_EN to add the same-tag hazard_out output.
module zero_count_pipe
    import zcp_pkg::*;
#(
    parameter int WIDTH = ZCP_WIDTH,
    parameter int CHUNK = ZCP_CHUNK,
    parameter int TAG_W = ZCP_TAG_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [WIDTH-1:0]        in,
    input  logic                    mode_in,
    input  logic [TAG_W-1:0]        tag_in,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    valid_out,
    output logic                    zero_out,
    output logic [cnt_w(WIDTH)-1:0] count_out,
    output logic [TAG_W-1:0]        tag_out
`ifdef ZCP_BYPASS_EN
    ,
    output logic                    hazard_out
`endif
);

    localparam int N   = WIDTH / CHUNK;
    localparam int CW  = cnt_w(WIDTH);
    localparam int CCW = cnt_w(CHUNK);

    // Ones mode inverts the operand so one datapath serves both modes.
    logic [WIDTH-1:0] eff_p0;
    logic [N-1:0]     cz_p0;
    logic [CCW-1:0]   cc_p0 [N];

    assign eff_p0 = (mode_in == MODE_ONES) ? ~in : in;

    for (genvar g = 0; g < N; g++) begin : g_chunk
        chunk_lzc #(.CHUNK(CHUNK)) u_chunk (
            .data (eff_p0[WIDTH-1-g*CHUNK -: CHUNK]),
            .zero (cz_p0[g]),
            .cnt  (cc_p0[g])
        );
    end

    // ---- S1 registers ----
    logic             vld_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [N-1:0]     cz_p1;
    logic [CCW-1:0]   cc_p1 [N];

    // ---- S2 combine: lowest non-zero chunk index decides the count ----
    logic          zero_s2;
    logic [CW-1:0] count_s2;

    always_comb begin
        zero_s2  = &cz_p1;
        count_s2 = CW'(WIDTH);
        for (int k = N - 1; k >= 0; k--) begin
            if (!cz_p1[k]) begin
                count_s2 = CW'(k * CHUNK) + CW'(cc_p1[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            tag_p1    <= '0;
            cz_p1     <= '0;
            for (int i = 0; i < N; i++) begin
                cc_p1[i] <= '0;
            end
            valid_out <= 1'b0;
            zero_out  <= 1'b0;
            count_out <= '0;
            tag_out   <= '0;
`ifdef ZCP_BYPASS_EN
            hazard_out <= 1'b0;
`endif
        end else if (flush) begin
            vld_p1    <= 1'b0;
            valid_out <= 1'b0;
`ifdef ZCP_BYPASS_EN
            hazard_out <= 1'b0;
`endif
        end else if (!stall) begin
            vld_p1    <= valid_in;
            tag_p1    <= tag_in;
            cz_p1     <= cz_p0;
            cc_p1     <= cc_p0;
            valid_out <= vld_p1;
            zero_out  <= zero_s2;
            count_out <= count_s2;
            tag_out   <= tag_p1;
`ifdef ZCP_BYPASS_EN
            // Next S2 content is the current S1 op; next S1 content is the incoming op.
            hazard_out <= vld_p1 && valid_in && (tag_in == tag_p1);
`endif
        end
    end

endmodule

// File: tb/tb_zero_count_pipe.sv
// Self-checking bench for zero_count_pipe at 32/8, 16/4 and 64/16 configurations.
module tb_zero_count_pipe;

    logic        clk = 1'b0;
    logic        reset, valid_in, mode_in, stall, flush;
    logic [63:0] in64;
    logic [4:0]  tag_in;

    logic v0, z0, v1, z1, v2, z2;
    logic [5:0] c0;
    logic [4:0] c1;
    logic [6:0] c2;
    logic [4:0] t0, t1, t2;
`ifdef ZCP_BYPASS_EN
    logic h0, h1, h2;
`endif

    always #5 clk = ~clk;

    zero_count_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .in(in64[31:0]),
        .mode_in(mode_in), .tag_in(tag_in), .stall(stall), .flush(flush),
        .valid_out(v0), .zero_out(z0), .count_out(c0), .tag_out(t0)
`ifdef ZCP_BYPASS_EN
        , .hazard_out(h0)
`endif
    );

    zero_count_pipe #(.WIDTH(16), .CHUNK(4), .TAG_W(5)) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .in(in64[15:0]),
        .mode_in(mode_in), .tag_in(tag_in), .stall(stall), .flush(flush),
        .valid_out(v1), .zero_out(z1), .count_out(c1), .tag_out(t1)
`ifdef ZCP_BYPASS_EN
        , .hazard_out(h1)
`endif
    );

    zero_count_pipe #(.WIDTH(64), .CHUNK(16), .TAG_W(5)) dut2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .in(in64),
        .mode_in(mode_in), .tag_in(tag_in), .stall(stall), .flush(flush),
        .valid_out(v2), .zero_out(z2), .count_out(c2), .tag_out(t2)
`ifdef ZCP_BYPASS_EN
        , .hazard_out(h2)
`endif
    );

    typedef struct packed {
        logic            v;
        logic [2:0]      z;
        logic [2:0][6:0] c;
        logic [4:0]      t;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic        m;
        logic [4:0]  t;
        logic        z;
        logic [5:0]  c;
    } vec_t;

    exp_t       m1, m2;
    int         total = 0;
    int         bad = 0;
    logic [4:0] obs[$];
    logic       rec = 1'b0;
    vec_t       tbl[12];
    logic [4:0] stream_tags[4];

    function automatic int wof(input int d);
        return (d == 0) ? 32 : ((d == 1) ? 16 : 64);
    endfunction

    // Leading count = width minus the bit-length of the effective operand.
    function automatic logic [6:0] ref_cnt(input logic [63:0] x, input int w, input logic m);
        logic [63:0] e;
        int n;
        e = m ? ~x : x;
        if (w < 64) e = e & ((64'd1 << w) - 64'd1);
        n = 0;
        while (e != 0) begin
            e = e >> 1;
            n++;
        end
        return 7'(w - n);
    endfunction

    function automatic exp_t mk(input logic acc, input logic [63:0] x, input logic m, input logic [4:0] t);
        exp_t r;
        r.v = acc;
        r.t = t;
        for (int d = 0; d < 3; d++) begin
            r.c[d] = ref_cnt(x, wof(d), m);
            r.z[d] = (int'(r.c[d]) == wof(d));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: update the two-slot model from the rules, then compare every DUT.
    task automatic cycle();
        exp_t nw;
        logic st, fl, rs;
        st = stall;
        fl = flush;
        rs = reset;
        nw = mk(valid_in && !stall && !flush && !reset, in64, mode_in, tag_in);
        @(posedge clk);
        if (rs || fl) begin
            m1.v = 1'b0;
            m2.v = 1'b0;
        end else if (!st) begin
            m2 = m1;
            m1 = nw;
        end
        #1;
        if (rec && !rs && !fl && !st && v0) obs.push_back(t0);
        chk("valid32", 64'(v0), 64'(m2.v));
        chk("valid16", 64'(v1), 64'(m2.v));
        chk("valid64", 64'(v2), 64'(m2.v));
        if (m2.v) begin
            chk("zero32", 64'(z0), 64'(m2.z[0]));
            chk("cnt32",  64'(c0), 64'(m2.c[0]));
            chk("tag32",  64'(t0), 64'(m2.t));
            chk("zero16", 64'(z1), 64'(m2.z[1]));
            chk("cnt16",  64'(c1), 64'(m2.c[1]));
            chk("tag16",  64'(t1), 64'(m2.t));
            chk("zero64", 64'(z2), 64'(m2.z[2]));
            chk("cnt64",  64'(c2), 64'(m2.c[2]));
            chk("tag64",  64'(t2), 64'(m2.t));
        end
`ifdef ZCP_BYPASS_EN
        chk("hazard32", 64'(h0), 64'(m2.v && m1.v && (m2.t == m1.t)));
        chk("hazard64", 64'(h2), 64'(m2.v && m1.v && (m2.t == m1.t)));
`endif
    endtask

    task automatic drive(input logic v, input logic [63:0] x, input logic m, input logic [4:0] t);
        valid_in = v;
        in64     = x;
        mode_in  = m;
        tag_in   = t;
    endtask

    initial begin
        tbl[0]  = '{32'h0000_0000, 1'b0, 5'd3,  1'b1, 6'd32};
        tbl[1]  = '{32'h0001_0000, 1'b0, 5'd4,  1'b0, 6'd15};
        tbl[2]  = '{32'h8000_0000, 1'b0, 5'd5,  1'b0, 6'd0};
        tbl[3]  = '{32'hFFFF_FFFF, 1'b1, 5'd6,  1'b1, 6'd32};
        tbl[4]  = '{32'hFF0F_0000, 1'b1, 5'd7,  1'b0, 6'd8};
        tbl[5]  = '{32'h0000_00FF, 1'b0, 5'd8,  1'b0, 6'd24};
        tbl[6]  = '{32'h0000_0001, 1'b0, 5'd9,  1'b0, 6'd31};
        tbl[7]  = '{32'hFFFF_FFFE, 1'b1, 5'd10, 1'b0, 6'd31};
        tbl[8]  = '{32'h7FFF_FFFF, 1'b1, 5'd11, 1'b0, 6'd0};
        tbl[9]  = '{32'h0000_0000, 1'b1, 5'd12, 1'b0, 6'd0};
        tbl[10] = '{32'h00F0_0000, 1'b0, 5'd13, 1'b0, 6'd8};
        tbl[11] = '{32'h0008_0000, 1'b0, 5'd14, 1'b0, 6'd12};
        stream_tags = '{5'd20, 5'd21, 5'd22, 5'd23};

        m1 = '0;
        m2 = '0;
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        cycle();
        cycle();
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_zero",  64'(z0), 64'd0);
        chk("rst_count", 64'(c0), 64'd0);
        chk("rst_tag",   64'(t0), 64'd0);
        reset = 1'b0;

        // Back-to-back table stream; result i appears one step after i+1 is issued.
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) drive(1'b1, {32'h0, tbl[i].x}, tbl[i].m, tbl[i].t);
            else        drive(1'b0, 64'd0, 1'b0, 5'd0);
            cycle();
            if (i >= 1) begin
                chk("tbl_valid", 64'(v0), 64'd1);
                chk("tbl_zero",  64'(z0), 64'(tbl[i-1].z));
                chk("tbl_count", 64'(c0), 64'(tbl[i-1].c));
                chk("tbl_tag",   64'(t0), 64'(tbl[i-1].t));
            end
        end
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        cycle();

        // Four ops with a two-cycle stall in the middle.
        obs.delete();
        rec = 1'b1;
        drive(1'b1, 64'h0000_0000_0000_0F00, 1'b0, stream_tags[0]); cycle();
        drive(1'b1, 64'hF000_0000_FFFF_0000, 1'b1, stream_tags[1]); cycle();
        drive(1'b1, 64'h0000_0000_0000_0003, 1'b0, stream_tags[2]);
        stall = 1'b1; cycle(); cycle();
        stall = 1'b0; cycle();
        drive(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, stream_tags[3]); cycle();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        cycle(); cycle(); cycle();
        rec = 1'b0;
        chk("stream_count", 64'(obs.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs.size()) chk("stream_order", 64'(obs[i]), 64'(stream_tags[i]));
        end

        // Two same-tag ops in flight, then flush together with stall.
        drive(1'b1, 64'h0000_0000_0000_1000, 1'b0, 5'd7); cycle();
        drive(1'b1, 64'h0000_0000_0000_0010, 1'b0, 5'd7); cycle();
        flush = 1'b1;
        stall = 1'b1;
        cycle();
        chk("flush_v1", 64'(v0), 64'd0);
`ifdef ZCP_BYPASS_EN
        chk("flush_h1", 64'(h0), 64'd0);
`endif
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        cycle();
        chk("flush_v2", 64'(v0), 64'd0);
`ifdef ZCP_BYPASS_EN
        chk("flush_h2", 64'(h0), 64'd0);
`endif

        // Reset while an op sits in S2.
        drive(1'b1, 64'h0000_0000_00F0_0000, 1'b0, 5'd9); cycle();
        drive(1'b1, 64'h0000_0000_0000_0001, 1'b0, 5'd10); cycle();
        reset = 1'b1;
        cycle();
        chk("midrst_valid", 64'(v0), 64'd0);
        chk("midrst_zero",  64'(z0), 64'd0);
        chk("midrst_count", 64'(c0), 64'd0);
        chk("midrst_tag",   64'(t0), 64'd0);
        chk("midrst_cnt64", 64'(c2), 64'd0);
        chk("midrst_tag16", 64'(t1), 64'd0);
        reset = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0);

        // Random traffic across all three configurations.
        for (int n = 0; n < 600; n++) begin
            logic [63:0] x;
            logic        m;
            x = {$urandom, $urandom} >> $urandom_range(0, 64);
            m = 1'($urandom_range(0, 1));
            if (m) x = ~x;
            drive($urandom_range(0, 3) != 0, x, m, 5'($urandom_range(0, 3)));
            stall = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        stall = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
